// File: rtl/first_counter_pkg.sv
// first_counter_pkg: shared state encoding, default width and MAX helper for the counter monitor
package first_counter_pkg;
  typedef enum logic [1:0] {UNSYNC, TRACK, FAIL} state_t;
  localparam int WIDTH_DEF = 4;
  function automatic int max_of(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/first_counter_model.sv
// first_counter_model: reference model of the monitored counter, with reload and resync from observed values
module first_counter_model
  import first_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             load,
  input  logic             enable,
  input  logic             step,
  input  logic             resync,
  input  logic [WIDTH-1:0] resync_cnt,
  input  logic             resync_ovf,
  output logic [WIDTH-1:0] exp_cnt,
  output logic             exp_ovf,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(max_of(WIDTH));
  always_comb wrap = step && enable && exp_cnt == MAX;
  always_ff @(posedge clk) begin
    if (load) begin
      exp_cnt <= '0;
      exp_ovf <= 1'b0;
    end else if (resync) begin
      exp_cnt <= resync_cnt + WIDTH'(enable);
      exp_ovf <= resync_ovf || resync_cnt == MAX;
    end else if (step) begin
      exp_cnt <= exp_cnt + WIDTH'(enable);
      exp_ovf <= exp_ovf || exp_cnt == MAX;
    end
  end
endmodule

// File: rtl/first_counter_monitor.sv
// first_counter_monitor: passive checker comparing a first_counter against its model, with stats and first-failure capture
module first_counter_monitor
  import first_counter_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int ERR_W       = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             dut_reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] counter_out,
  input  logic             overflow_out,
  output logic             synced_o,
  output logic             err_cnt_o,
  output logic             err_ovf_o,
  output logic             fail_o,
  output logic [ERR_W-1:0] mismatch_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [WIDTH:0]   first_err_exp,
  output logic [WIDTH:0]   first_err_obs
);
  state_t state;
  logic [WIDTH-1:0] exp_cnt;
  logic exp_ovf, wrap, cmp, load, bad_cnt, bad_ovf, bad;
  always_comb begin
    cmp     = state == TRACK && !dut_reset && !clear;
    load    = dut_reset && (clear || state != FAIL);
    bad_cnt = cmp && counter_out != exp_cnt;
    bad_ovf = cmp && overflow_out != exp_ovf;
    bad     = bad_cnt || bad_ovf;
  end
  assign synced_o = state == TRACK;
  first_counter_model #(.WIDTH(WIDTH)) u_model (
    .clk       (clk),
    .load      (load),
    .enable    (enable),
    .step      (cmp),
    .resync    (bad && STOP_ON_ERR == 0),
    .resync_cnt(counter_out),
    .resync_ovf(overflow_out),
    .exp_cnt   (exp_cnt),
    .exp_ovf   (exp_ovf),
    .wrap      (wrap)
  );
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state          <= (!reset && dut_reset) ? TRACK : UNSYNC;
      err_cnt_o      <= 1'b0;
      err_ovf_o      <= 1'b0;
      fail_o         <= 1'b0;
      mismatch_count <= '0;
      wrap_count     <= '0;
      first_err_exp  <= '0;
      first_err_obs  <= '0;
    end else begin
      err_cnt_o <= bad_cnt;
      err_ovf_o <= bad_ovf;
      if (state == UNSYNC && dut_reset) state <= TRACK;
      if (bad) begin
        fail_o         <= 1'b1;
        mismatch_count <= mismatch_count + ERR_W'(mismatch_count != '1);
        if (!fail_o) begin
          first_err_exp <= {exp_ovf, exp_cnt};
          first_err_obs <= {overflow_out, counter_out};
        end
        if (STOP_ON_ERR != 0) state <= FAIL;
      end
      if (wrap) wrap_count <= wrap_count + ERR_W'(wrap_count != '1);
    end
  end
endmodule

// File: tb/tb_first_counter_monitor.sv
// tb_first_counter_monitor: three monitor configurations against a behavioural counter and a spec-level reference model
module tb_first_counter_monitor;
  logic clk = 0, reset = 1, clear = 0, dut_reset = 0, enable = 0, overflow_out = 0;
  logic [3:0] counter_out = 0;
  logic s0, c0, o0, f0, s1, c1, o1, f1, s2, c2, o2, f2;
  logic [7:0] m0, w0, m1, w1;
  logic [1:0] m2, w2;
  logic [4:0] fe0, fo0, fe1, fo1, fe2, fo2;
  int st[3], ec[3], eo[3], pc[3], po[3], fl[3], mm[3], wr[3], fe[3], fo[3];
  int g_cnt = 0, g_ovf = 0;
  bit stuck = 0, rnd = 0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  first_counter_monitor #(.WIDTH(4), .ERR_W(8), .STOP_ON_ERR(0)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .dut_reset(dut_reset), .enable(enable),
    .counter_out(counter_out), .overflow_out(overflow_out), .synced_o(s0), .err_cnt_o(c0),
    .err_ovf_o(o0), .fail_o(f0), .mismatch_count(m0), .wrap_count(w0),
    .first_err_exp(fe0), .first_err_obs(fo0));
  first_counter_monitor #(.WIDTH(4), .ERR_W(8), .STOP_ON_ERR(1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .dut_reset(dut_reset), .enable(enable),
    .counter_out(counter_out), .overflow_out(overflow_out), .synced_o(s1), .err_cnt_o(c1),
    .err_ovf_o(o1), .fail_o(f1), .mismatch_count(m1), .wrap_count(w1),
    .first_err_exp(fe1), .first_err_obs(fo1));
  first_counter_monitor #(.WIDTH(4), .ERR_W(2), .STOP_ON_ERR(0)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .dut_reset(dut_reset), .enable(enable),
    .counter_out(counter_out), .overflow_out(overflow_out), .synced_o(s2), .err_cnt_o(c2),
    .err_ovf_o(o2), .fail_o(f2), .mismatch_count(m2), .wrap_count(w2),
    .first_err_exp(fe2), .first_err_obs(fo2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_step(input int i);
    int mx = (i == 2) ? 3 : 255;
    bit bc, bo;
    pc[i] = 0;
    po[i] = 0;
    if (reset) begin
      st[i] = 0; ec[i] = 0; eo[i] = 0; fl[i] = 0; mm[i] = 0; wr[i] = 0; fe[i] = 0; fo[i] = 0;
    end else if (clear) begin
      fl[i] = 0; mm[i] = 0; wr[i] = 0; fe[i] = 0; fo[i] = 0;
      st[i] = dut_reset ? 1 : 0;
      if (dut_reset) begin ec[i] = 0; eo[i] = 0; end
    end else if (st[i] == 0) begin
      if (dut_reset) begin ec[i] = 0; eo[i] = 0; st[i] = 1; end
    end else if (st[i] == 1) begin
      if (dut_reset) begin
        ec[i] = 0; eo[i] = 0;
      end else begin
        bc = int'(counter_out) != ec[i];
        bo = int'(overflow_out) != eo[i];
        if (enable && ec[i] == 15 && wr[i] < mx) wr[i]++;
        if (bc || bo) begin
          pc[i] = int'(bc); po[i] = int'(bo);
          if (mm[i] < mx) mm[i]++;
          if (fl[i] == 0) begin
            fe[i] = eo[i] * 16 + ec[i];
            fo[i] = int'(overflow_out) * 16 + int'(counter_out);
          end
          fl[i] = 1;
          if (i == 1) st[i] = 2;
          else begin
            ec[i] = (int'(counter_out) + int'(enable)) % 16;
            eo[i] = (overflow_out || counter_out == 4'd15) ? 1 : 0;
          end
        end else begin
          eo[i] = (eo[i] != 0 || ec[i] == 15) ? 1 : 0;
          ec[i] = (ec[i] + int'(enable)) % 16;
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic s, input logic c, input logic o, input logic f,
                            input logic [7:0] m, input logic [7:0] w, input logic [4:0] e, input logic [4:0] b);
    check($sformatf("u%0d synced", i), 32'(s), 32'(st[i] == 1));
    check($sformatf("u%0d err_cnt", i), 32'(c), pc[i]);
    check($sformatf("u%0d err_ovf", i), 32'(o), po[i]);
    check($sformatf("u%0d fail", i), 32'(f), fl[i]);
    check($sformatf("u%0d mismatch_count", i), 32'(m), mm[i]);
    check($sformatf("u%0d wrap_count", i), 32'(w), wr[i]);
    check($sformatf("u%0d first_err_exp", i), 32'(e), fe[i]);
    check($sformatf("u%0d first_err_obs", i), 32'(b), fo[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    if (dut_reset) begin
      g_cnt = 0; g_ovf = 0;
    end else begin
      if (g_cnt == 15) g_ovf = 1;
      if (enable && !stuck) g_cnt = (g_cnt + 1) % 16;
    end
    #1;
    check_inst(0, s0, c0, o0, f0, m0, w0, fe0, fo0);
    check_inst(1, s1, c1, o1, f1, m1, w1, fe1, fo1);
    check_inst(2, s2, c2, o2, f2, {6'd0, m2}, {6'd0, w2}, fe2, fo2);
    if (rnd) begin
      counter_out  = 4'($urandom);
      overflow_out = 1'($urandom);
    end else begin
      counter_out  = 4'(g_cnt);
      overflow_out = g_ovf[0];
    end
  endtask

  task automatic stuck_fault();
    stuck = 1;
    tick();
    stuck = 0;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    reset = 0;
    rnd = 1;
    repeat (30) begin
      enable = 1'($urandom);
      tick();
    end
    check("unsync synced", 32'(s0), 0);
    check("unsync mismatch", 32'(m0), 0);
    rnd = 0;
    enable = 1;
    dut_reset = 1;
    tick();
    dut_reset = 0;
    repeat (20) tick();
    check("run synced", 32'(s0), 1);
    check("run wraps", 32'(w0), 1);
    check("run mismatch", 32'(m0), 0);
    check("run fail", 32'(f0), 0);
    check("run ovf", 32'(overflow_out), 1);
    dut_reset = 1;
    tick();
    dut_reset = 0;
    repeat (5) tick();
    stuck_fault();
    check("stuck pulse", 32'(c0), 1);
    check("stuck count", 32'(m0), 1);
    check("stuck exp", 32'(fe0), 32'h06);
    check("stuck obs", 32'(fo0), 32'h05);
    tick();
    check("resync clean", 32'(c0), 0);
    clear = 1;
    tick();
    clear = 0;
    check("clear synced", 32'(s0), 0);
    check("clear count", 32'(m0), 0);
    dut_reset = 1;
    tick();
    dut_reset = 0;
    repeat (3) tick();
    g_ovf = 1;
    overflow_out = 1;
    tick();
    check("ovf pulse", 32'(o0), 1);
    check("stop synced", 32'(s1), 0);
    repeat (4) stuck_fault();
    check("stop frozen", 32'(m1), 1);
    check("sat count", 32'(m2), 3);
    check("full count", 32'(m0), 5);
    clear = 1;
    dut_reset = 1;
    tick();
    clear = 0;
    dut_reset = 0;
    check("clear+sync synced", 32'(s1), 1);
    repeat (3) tick();
    check("clear+sync clean", 32'(m1), 0);
    stuck = 1;
    tick();
    stuck = 0;
    reset = 1;
    tick();
    reset = 0;
    check("reset no pulse", 32'(c0), 0);
    check("reset synced", 32'(s0), 0);
    tick();
    repeat (300) begin
      enable    = $urandom_range(0, 3) != 0;
      dut_reset = $urandom_range(0, 19) == 0;
      clear     = $urandom_range(0, 49) == 0;
      reset     = $urandom_range(0, 99) == 0;
      stuck     = $urandom_range(0, 14) == 0;
      if ($urandom_range(0, 29) == 0) begin
        g_ovf = 1;
        overflow_out = 1;
      end
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
